// File: rtl/mux16_rr_arbiter_if.sv
// Handshake/bus bundle between the mux16 round-robin arbiter and its
// requesters/consumer. The lock vector exists only when ARB_LOCK_EN is defined.
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ack;
`ifdef ARB_LOCK_EN
  logic [15:0] lock;
`endif

  // Arbiter side: consumes requests and ready, drives selector/grant/handshake.
  modport master (
`ifdef ARB_LOCK_EN
    input  lock,
`endif
    input  req,
    input  out_ready,
    output sel,
    output gnt,
    output out_valid,
    output ack
  );

  // Requester/consumer side.
  modport slave (
`ifdef ARB_LOCK_EN
    output lock,
`endif
    output req,
    output out_ready,
    input  sel,
    input  gnt,
    input  out_valid,
    input  ack
  );
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 16-input mux16_1 datapath.
// Drives the mux selector, a one-hot grant and a valid/ready handshake, and
// pulses a per-requester ack on each completed transfer.
// Optional feature macro: ARB_LOCK_EN (burst hold of up to MAX_BURST beats).
module mux16_rr_arbiter #(
  parameter int CNT_W = 8
`ifdef ARB_LOCK_EN
  , parameter int MAX_BURST = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux16_rr_arbiter_if.master   bus,
  output logic [CNT_W-1:0]     xfer_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ARB_LOCK_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};
`endif

  // First set bit of mask scanning upward from last+1 with wrap; {found, idx}.
  function automatic logic [4:0] rr_pick(input logic [15:0] mask, input logic [3:0] last);
    logic       found;
    logic [3:0] idx;
    logic [3:0] cand;
    found = 1'b0;
    idx   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      cand = last + 4'd1 + 4'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         sel_q, sel_d;
  logic [15:0]        gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef ARB_LOCK_EN
  logic [BURST_W-1:0] burst_q, burst_d;
`endif

  logic        hs_s;
  logic        keep_s;
  logic [15:0] mask_s;
  logic        found_s;
  logic [3:0]  idx_s;

  assign hs_s = valid_q & bus.out_ready;

  // The granted requester is excluded from re-arbitration so rotation always advances.
  assign mask_s = (state_q == GRANT) ? (bus.req & ~gnt_q) : bus.req;
  assign {found_s, idx_s} = rr_pick(mask_s, ptr_q);

`ifdef ARB_LOCK_EN
  assign keep_s = bus.lock[sel_q] & bus.req[sel_q] & (burst_q < BURST_LAST);
`else
  assign keep_s = 1'b0;
`endif

  // Next-state and next-output computation for the IDLE/GRANT sequencer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef ARB_LOCK_EN
    burst_d = burst_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          sel_d   = idx_s;
          gnt_d   = 16'd1 << idx_s;
          valid_d = 1'b1;
          ptr_d   = idx_s;
`ifdef ARB_LOCK_EN
          burst_d = {BURST_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (hs_s) begin
          cnt_d = cnt_q + CNT_ONE;
          if (keep_s) begin
`ifdef ARB_LOCK_EN
            burst_d = burst_q + BURST_ONE;
`endif
          end else if (found_s) begin
            // Back-to-back grant: valid stays high, no idle bubble.
            state_d = GRANT;
            sel_d   = idx_s;
            gnt_d   = 16'd1 << idx_s;
            valid_d = 1'b1;
            ptr_d   = idx_s;
`ifdef ARB_LOCK_EN
            burst_d = {BURST_W{1'b0}};
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = 16'd0;
            valid_d = 1'b0;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 16'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; asynchronous reset points the search at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      gnt_q   <= 16'd0;
      valid_q <= 1'b0;
      ptr_q   <= 4'd15;
      cnt_q   <= {CNT_W{1'b0}};
`ifdef ARB_LOCK_EN
      burst_q <= {BURST_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef ARB_LOCK_EN
      burst_q <= burst_d;
`endif
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = valid_q;
  assign bus.ack       = gnt_q & {16{hs_s}};
  assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed, table-driven bench for mux16_rr_arbiter plus hand-written
// sequences for reset, rotation, counter wrap and (if ARB_LOCK_EN) burst lock.
module tb_mux16_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] xfer_cnt;
  int         n_checks;
  int         n_pass;

  mux16_rr_arbiter_if bus ();

  mux16_rr_arbiter #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        valid;
    logic [15:0] ack;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] sel, input logic [15:0] gnt,
                           input logic valid, input logic [15:0] ack, input logic [7:0] cnt);
    check({tag, ".sel"},   {28'd0, bus.sel},       {28'd0, sel});
    check({tag, ".gnt"},   {16'd0, bus.gnt},       {16'd0, gnt});
    check({tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, valid});
    check({tag, ".ack"},   {16'd0, bus.ack},       {16'd0, ack});
    check({tag, ".cnt"},   {24'd0, xfer_cnt},      {24'd0, cnt});
  endtask

  task automatic set_in(input logic [15:0] req, input logic rdy);
    bus.req       = req;
    bus.out_ready = rdy;
  endtask

  initial begin
    logic [3:0]  idx;
    logic [7:0]  ecnt;
    n_checks = 0;
    n_pass   = 0;

    //           req       rdy   sel   gnt        val   ack        cnt
    vecs[0]  = '{16'h0088, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 8'd0}; // idle after reset
    vecs[1]  = '{16'h0088, 1'b0, 4'd3, 16'h0008, 1'b1, 16'h0000, 8'd0}; // granted 3, stalled
    vecs[2]  = '{16'h0088, 1'b0, 4'd3, 16'h0008, 1'b1, 16'h0000, 8'd0};
    vecs[3]  = '{16'h0088, 1'b0, 4'd3, 16'h0008, 1'b1, 16'h0000, 8'd0};
    vecs[4]  = '{16'h0088, 1'b0, 4'd3, 16'h0008, 1'b1, 16'h0000, 8'd0};
    vecs[5]  = '{16'h0088, 1'b0, 4'd3, 16'h0008, 1'b1, 16'h0000, 8'd0};
    vecs[6]  = '{16'h0088, 1'b1, 4'd3, 16'h0008, 1'b1, 16'h0008, 8'd0}; // handshake on 3
    vecs[7]  = '{16'h0088, 1'b1, 4'd7, 16'h0080, 1'b1, 16'h0080, 8'd1}; // zero bubble to 7
    vecs[8]  = '{16'h0000, 1'b0, 4'd3, 16'h0008, 1'b1, 16'h0000, 8'd2}; // req drop ignored
    vecs[9]  = '{16'h0000, 1'b1, 4'd3, 16'h0008, 1'b1, 16'h0008, 8'd2};
    vecs[10] = '{16'h0010, 1'b1, 4'd3, 16'h0000, 1'b0, 16'h0000, 8'd3}; // idle, ready no effect
    vecs[11] = '{16'h0010, 1'b1, 4'd4, 16'h0010, 1'b1, 16'h0010, 8'd3}; // single beat on 4
    vecs[12] = '{16'h0010, 1'b1, 4'd4, 16'h0000, 1'b0, 16'h0000, 8'd4}; // masked -> idle 1 cycle
    vecs[13] = '{16'h0010, 1'b0, 4'd4, 16'h0010, 1'b1, 16'h0000, 8'd4}; // re-granted 4

    rst_n = 1'b0;
    set_in(16'h0000, 1'b0);
`ifdef ARB_LOCK_EN
    bus.lock = 16'h0000;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      set_in(vecs[v].req, vecs[v].rdy);
      #1;
      check_all($sformatf("vec%0d", v), vecs[v].sel, vecs[v].gnt, vecs[v].valid, vecs[v].ack, vecs[v].cnt);
    end

    // Move to a grant on 5, then assert reset between clock edges.
    @(negedge clk);
    set_in(16'h0020, 1'b1);
    @(negedge clk);
    set_in(16'h0020, 1'b0);
    #1;
    check_all("pre_rst", 4'd5, 16'h0020, 1'b1, 16'h0000, 8'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'd0, 16'h0000, 1'b0, 16'h0000, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(16'h0001, 1'b0);
    @(negedge clk);
    #1;
    check_all("post_rst", 4'd0, 16'h0001, 1'b1, 16'h0000, 8'd0);

    // Full rotation under continuous ready; continue to 256 beats for counter wrap.
    @(negedge clk);
    rst_n = 1'b0;
    set_in(16'hFFFF, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      #1;
      idx  = i[3:0];
      ecnt = i[7:0];
      check($sformatf("rot%0d.sel", i),   {28'd0, bus.sel},       {28'd0, idx});
      check($sformatf("rot%0d.gnt", i),   {16'd0, bus.gnt},       {16'd0, 16'd1 << idx});
      check($sformatf("rot%0d.valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("rot%0d.cnt", i),   {24'd0, xfer_cnt},      {24'd0, ecnt});
    end

`ifdef ARB_LOCK_EN
    // Burst lock on requester 0 with MAX_BURST=4.
    begin
      logic [3:0] lock_seq[10];
      lock_seq = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
      @(negedge clk);
      rst_n = 1'b0;
      set_in(16'h0003, 1'b1);
      bus.lock = 16'h0001;
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        #1;
        check($sformatf("lock%0d.sel", j), {28'd0, bus.sel}, {28'd0, lock_seq[j]});
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux16_rr_arbiter.md
Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-input, 16-bit mux16_1 datapath.
- Sixteen requesters each present a 16-bit word on one mux input and raise req.
- Block drives the 4-bit mux selector, one-hot grant and a valid/ready handshake to the downstream consumer.
- Pulses a per-requester ack when its word is taken.

Parameters:
- CNT_W, 8, width of transfer counter xfer_cnt.
- MAX_BURST, 4, max consecutive beats per grant (used only with ARB_LOCK_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request per requester; bit i pairs with mux input i+1 (selector value i).
- sel  output  4  selector to mux16_1.
- gnt  output  16  one-hot grant, all-zero when idle.
- out_valid  output  1  mux output holds granted word.
- out_ready  input  1  consumer accepts word.
- ack  output  16  one-hot, combinational: gnt & {16{out_valid & out_ready}}.
- xfer_cnt  output  CNT_W  count of completed handshakes.
- lock  input  16  burst-hold request per requester (only when ARB_LOCK_EN defined).

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset clears immediately, no clock needed, including mid-transfer:
  - state=IDLE, sel=0, gnt=0, out_valid=0, xfer_cnt=0.
  - ptr (last granted index) = 15, so the first search starts at index 0.
- States: IDLE and GRANT.
- IDLE:
  - If req != 0: select first set bit scanning (ptr+1+k) mod 16, k=0..15.
  - On the next edge: state=GRANT, sel=idx, gnt=1<<idx, out_valid=1, ptr=idx. Latency req -> out_valid is 1 cycle.
  - If req == 0: stay in IDLE; sel holds its last value.
- GRANT:
  - sel, gnt and out_valid are stable while out_ready=0. No retraction; req deassertion during GRANT is ignored.
  - Requesters must hold their word until ack.
- Handshake cycle (out_valid & out_ready):
  - ack[idx]=1 for that cycle only; xfer_cnt increments, wrapping 2^CNT_W-1 -> 0.
  - Re-arbitrate over req & ~gnt starting at ptr+1. The current requester is masked even if its req is still high.
  - If another request is found: next edge loads the new grant directly; zero bubble, out_valid stays 1.
  - If none is found: next edge -> IDLE, out_valid=0, gnt=0.
- Simultaneous requests: rotation guarantees each active requester is served within 16 beats.
- out_ready while out_valid=0 has no effect; ack stays 0.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - lock port exists; internal beat counter burst is reset to 0 on each new grant.
  - In a handshake cycle, if lock[idx]=1, req[idx]=1 and burst < MAX_BURST-1: keep the same grant, do not mask, ptr unchanged, burst increments.
  - Otherwise rotate normally.
- Undefined: no lock port, no burst counter; every grant is exactly one beat.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT (sel=5, out_valid=1) -> out_valid, gnt, xfer_cnt go 0 without a clock edge; after release with req=0x0001, sel=0 one cycle later.
- Rotation: req=0xFFFF held, out_ready=1 -> sel sequence 0,1,2,...,15,0 on consecutive cycles; out_valid continuously 1; xfer_cnt=16 after 16 beats.
- Backpressure: req=0x0088, out_ready=0 for 5 cycles -> sel=3, gnt=0x0008 stable, ack=0; raise out_ready -> ack=0x0008 that cycle; next cycle sel=7.
- Masking: only req[4]=1, held high through ack -> single beat, then IDLE (out_valid=0) for 1 cycle, then re-granted sel=4.
- Counter wrap (CNT_W=8): 256 handshakes -> xfer_cnt returns to 0.
- ARB_LOCK_EN: req=0x0003, lock=0x0001, MAX_BURST=4, out_ready=1 -> sel 0,0,0,0,1,0,0,0,0,1.
